// File: rtl/cache_repl_policy.sv
// Victim selection and replacement-state update for a set-associative cache:
// LFSR random, per-set round-robin, or per-set tree pseudo-LRU, plus a clear sweep.
module cache_repl_policy #(
  parameter int NUMWAYS = 4,
  parameter int NUMSETS = 128,
  parameter int SETLEN  = $clog2(NUMSETS),
  parameter int MODE    = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               FlushStage,
  input  logic               CacheEn,
  input  logic [NUMWAYS-1:0] HitWay,
  input  logic [NUMWAYS-1:0] ValidWay,
  input  logic [SETLEN-1:0]  CacheSet,
  input  logic [SETLEN-1:0]  PAdrSet,
  input  logic               LRUWriteEn,
  input  logic               InvalidateCache,
  output logic [NUMWAYS-1:0] VictimWay,
  output logic               Busy
);
  localparam int LOGW = $clog2(NUMWAYS);
  // Wide enough for a tree (NUMWAYS-1 bits) and for a LOGW-bit pointer.
  localparam int STW  = NUMWAYS - 1;

  logic [STW-1:0]    st [NUMSETS];
  logic [7:0]        lfsr;
  logic [SETLEN-1:0] cnt;
  logic              upd, hit, we, b;
  logic [STW-1:0]    rd_vic, rd_upd, wd, nt;
  logic [SETLEN-1:0] wa;
  logic [LOGW-1:0]   pidx, vidx, hidx, aw, pv, np;

  assign upd    = LRUWriteEn & CacheEn & ~FlushStage & ~Busy;
  assign rd_vic = st[CacheSet];
  assign rd_upd = st[PAdrSet];

  // Victim: tree walk from the root, bit 1 steers to the upper half.
  always_comb begin
    pv = '0;
    b  = 1'b0;
    for (int l = 0; l < LOGW; l++) begin
      b = 1'b0;
      for (int k = 0; k < (1 << l); k++)
        if (pv == LOGW'(k)) b = rd_vic[(1 << l) - 1 + k];
      pv = (pv << 1) | LOGW'(b);
    end
    case (MODE)
      0:       pidx = lfsr[LOGW-1:0];
      1:       pidx = rd_vic[LOGW-1:0];
      default: pidx = pv;
    endcase
    vidx = pidx;
    for (int i = NUMWAYS - 1; i >= 0; i--)
      if (!ValidWay[i]) vidx = LOGW'(i);
  end

  assign VictimWay = Busy ? NUMWAYS'(1) : (NUMWAYS'(1) << vidx);

  // Update path and the single shared state write port (sweep has priority).
  always_comb begin
    hidx = '0;
    for (int i = NUMWAYS - 1; i >= 0; i--)
      if (HitWay[i]) hidx = LOGW'(i);
    hit = |HitWay;
    aw  = hit ? hidx : vidx;
    nt  = rd_upd;
    for (int l = 0; l < LOGW; l++)
      for (int k = 0; k < (1 << l); k++)
        if ((aw >> (LOGW - l)) == LOGW'(k)) nt[(1 << l) - 1 + k] = ~aw[LOGW-1-l];
    np = rd_upd[LOGW-1:0] + 1'b1;
    we = 1'b0;
    wa = PAdrSet;
    wd = rd_upd;
    if (Busy) begin
      we = 1'b1;
      wa = cnt;
      wd = '0;
    end else if (upd && MODE == 1 && !hit) begin
      we = 1'b1;
      wd = STW'(np);
    end else if (upd && MODE == 2) begin
      we = 1'b1;
      wd = nt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Busy <= 1'b0;
      cnt  <= '0;
      lfsr <= 8'h01;
      for (int s = 0; s < NUMSETS; s++) st[s] <= '0;
    end else begin
      if (we) st[wa] <= wd;
      if (upd && MODE == 0) lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      if (!Busy) begin
        if (InvalidateCache) begin
          Busy <= 1'b1;
          cnt  <= '0;
        end
      end else if (InvalidateCache) begin
        cnt <= '0;
      end else if (cnt == SETLEN'(NUMSETS - 1)) begin
        Busy <= 1'b0;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_cache_repl_policy.sv
// Directed bench: one instance per MODE sharing stimulus, NUMWAYS=4, NUMSETS=8.
module tb_cache_repl_policy;
  localparam int NW = 4, NS = 8, SL = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          FlushStage, CacheEn, LRUWriteEn, InvalidateCache;
  logic [NW-1:0] HitWay, ValidWay;
  logic [SL-1:0] CacheSet, PAdrSet;
  logic [NW-1:0] v0, v1, v2;
  logic          bz0, bz1, bz2;
  int            errs = 0, nchk = 0;
  logic [7:0]    lf;

  always #5 clk = ~clk;

  cache_repl_policy #(.NUMWAYS(NW), .NUMSETS(NS), .MODE(0)) u0 (
    .clk(clk), .reset(reset), .FlushStage(FlushStage), .CacheEn(CacheEn),
    .HitWay(HitWay), .ValidWay(ValidWay), .CacheSet(CacheSet), .PAdrSet(PAdrSet),
    .LRUWriteEn(LRUWriteEn), .InvalidateCache(InvalidateCache),
    .VictimWay(v0), .Busy(bz0));
  cache_repl_policy #(.NUMWAYS(NW), .NUMSETS(NS), .MODE(1)) u1 (
    .clk(clk), .reset(reset), .FlushStage(FlushStage), .CacheEn(CacheEn),
    .HitWay(HitWay), .ValidWay(ValidWay), .CacheSet(CacheSet), .PAdrSet(PAdrSet),
    .LRUWriteEn(LRUWriteEn), .InvalidateCache(InvalidateCache),
    .VictimWay(v1), .Busy(bz1));
  cache_repl_policy #(.NUMWAYS(NW), .NUMSETS(NS), .MODE(2)) u2 (
    .clk(clk), .reset(reset), .FlushStage(FlushStage), .CacheEn(CacheEn),
    .HitWay(HitWay), .ValidWay(ValidWay), .CacheSet(CacheSet), .PAdrSet(PAdrSet),
    .LRUWriteEn(LRUWriteEn), .InvalidateCache(InvalidateCache),
    .VictimWay(v2), .Busy(bz2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] lnext(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction

  function automatic logic [NW-1:0] lway(input logic [7:0] x);
    logic [1:0] lo;
    lo = x[1:0];
    return NW'(1) << lo;
  endfunction

  // One qualified update on set s with hit vector h.
  task automatic upd(input logic [SL-1:0] s, input logic [NW-1:0] h);
    CacheSet = s; PAdrSet = s; HitWay = h;
    CacheEn = 1'b1; FlushStage = 1'b0; LRUWriteEn = 1'b1;
    tick;
    LRUWriteEn = 1'b0;
    lf = lnext(lf);
  endtask

  initial begin
    int n;
    FlushStage = 0; CacheEn = 0; LRUWriteEn = 0; InvalidateCache = 0;
    HitWay = '0; ValidWay = '1; CacheSet = '0; PAdrSet = '0; lf = 8'h01;
    #2 reset = 1'b1;
    #1;
    chk("rst_v0", v0, 4'b0010);
    chk("rst_v1", v1, 4'b0001);
    chk("rst_v2", v2, 4'b0001);
    chk("rst_busy", bz2, 0);
    tick; tick;
    reset = 1'b0;
    tick;

    ValidWay = 4'b0101; #1;
    chk("inv_v0", v0, 4'b0010);
    chk("inv_v1", v1, 4'b0010);
    chk("inv_v2", v2, 4'b0010);
    ValidWay = 4'b1111; #1;

    CacheEn = 1; LRUWriteEn = 1; FlushStage = 1; tick;
    chk("flush_v0", v0, 4'b0010);
    chk("flush_v1", v1, 4'b0001);
    chk("flush_v2", v2, 4'b0001);
    FlushStage = 0; CacheEn = 0; tick;
    chk("cen_v0", v0, 4'b0010);
    chk("cen_v1", v1, 4'b0001);
    chk("cen_v2", v2, 4'b0001);
    LRUWriteEn = 0;

    upd(0, '0); chk("lfsr_02", v0, 4'b0100);
    upd(0, '0); chk("lfsr_04", v0, 4'b0001);
    upd(0, '0); chk("lfsr_08", v0, 4'b0001);

    upd(3, 4'b0001); chk("plru_a", v2, 4'b0100); chk("rr_hit3", v1, 4'b0001);
    upd(3, 4'b0100); chk("plru_b", v2, 4'b0010);
    CacheSet = 4; #1; chk("plru_other", v2, 4'b0001);
    upd(6, 4'b1010); chk("plru_multi", v2, 4'b0100);

    upd(5, '0); chk("rr_1", v1, 4'b0010);
    upd(5, '0); chk("rr_2", v1, 4'b0100);
    upd(5, '0); chk("rr_3", v1, 4'b1000);
    upd(5, '0); chk("rr_wrap", v1, 4'b0001);
    upd(5, 4'b0010); chk("rr_hit", v1, 4'b0001);
    upd(5, '0); chk("rr_after_hit", v1, 4'b0010);
    chk("lfsr_model", v0, lway(lf));

    // Sweep with qualified-looking requests on set 0 throughout.
    InvalidateCache = 1; tick; InvalidateCache = 0;
    chk("sweep_busy0", bz0, 1);
    chk("sweep_busy1", bz1, 1);
    ValidWay = 4'b0101; #1;
    chk("sweep_force1", v1, 4'b0001);
    chk("sweep_force2", v2, 4'b0001);
    ValidWay = 4'b1111;
    CacheSet = 0; PAdrSet = 0; HitWay = '0; CacheEn = 1; LRUWriteEn = 1;
    n = 0;
    do begin tick; n++; end while (bz2 && n < 30);
    LRUWriteEn = 0;
    chk("sweep_len", n, 8);
    chk("sweep_lfsr", v0, lway(lf));
    for (int s = 0; s < NS; s++) begin
      CacheSet = SL'(s); #1;
      chk($sformatf("clr_v1_s%0d", s), v1, 4'b0001);
      chk($sformatf("clr_v2_s%0d", s), v2, 4'b0001);
    end

    // Restart: InvalidateCache on the third busy edge.
    InvalidateCache = 1; tick; InvalidateCache = 0;
    tick; tick;
    InvalidateCache = 1; tick; InvalidateCache = 0;
    n = 3;
    do begin tick; n++; end while (bz2 && n < 40);
    chk("restart_len", n, 11);

    // Reset during sweep cycle 3.
    upd(5, '0); chk("pre_rst_v1", v1, 4'b0010);
    InvalidateCache = 1; tick; InvalidateCache = 0;
    tick; tick;
    chk("mid_busy", bz2, 1);
    reset = 1'b1; #1;
    chk("rst_mid_busy", bz2, 0);
    chk("rst_mid_v1", v1, 4'b0001);
    chk("rst_mid_v0", v0, 4'b0010);
    lf = 8'h01;
    tick;
    reset = 1'b0;
    tick; tick;
    chk("post_rst_busy", bz2, 0);
    chk("post_rst_v1", v1, 4'b0001);

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end
endmodule

// File: doc/cache_repl_policy.md
CACHE_REPL_POLICY -- requirements
Module: cache_repl_policy

Interface
REQ-001 SHALL have parameter NUMWAYS, default 4: ways per set; power of 2, range 2..256.
REQ-002 SHALL have parameter NUMSETS, default 128: sets; power of 2, ≥2.
REQ-003 SHALL have parameter SETLEN, default $clog2(NUMSETS): set index width.
REQ-004 SHALL have parameter MODE, default 2: 0=LFSR random, 1=per-set round-robin, 2=per-set tree pseudo-LRU.
REQ-005 SHALL have port clk  in  1  the only clock, rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-high.
REQ-007 SHALL have port FlushStage  in  1  squash this cycle's update.
REQ-008 SHALL have port CacheEn  in  1  update enable.
REQ-009 SHALL have port HitWay  in  NUMWAYS  one-hot hit way; 0 = miss.
REQ-010 SHALL have port ValidWay  in  NUMWAYS  valid bits of the set addressed by CacheSet.
REQ-011 SHALL have port CacheSet  in  SETLEN  set index for victim read.
REQ-012 SHALL have port PAdrSet  in  SETLEN  set index for state update.
REQ-013 SHALL have port LRUWriteEn  in  1  update request.
REQ-014 SHALL have port InvalidateCache  in  1  start the clear sweep.
REQ-015 SHALL have port VictimWay  out  NUMWAYS  one-hot victim.
REQ-016 SHALL have port Busy  out  1  clear sweep in progress.

Function
REQ-017 SHALL qualify an update as Upd = LRUWriteEn & CacheEn & ~FlushStage & ~Busy.
REQ-018 SHALL compute VictimWay combinationally from stored state[CacheSet] and ValidWay (zero-cycle read); an update becomes visible the cycle after its edge, with no same-cycle bypass.
REQ-019 SHALL select the lowest-index way whose ValidWay bit is 0 when any way is invalid, regardless of MODE.
REQ-020 SHALL force VictimWay to one-hot way 0 while Busy=1.
REQ-021 MODE 0: SHALL use one global 8-bit Fibonacci LFSR; on Upd it shifts left with bit0 = b7^b5^b4^b3; victim index = low log2(NUMWAYS) bits.
REQ-022 MODE 0: the LFSR SHALL NOT be affected by InvalidateCache, and SHALL NOT be used when NUMWAYS > 256.
REQ-023 MODE 1: SHALL keep a log2(NUMWAYS)-bit pointer per set; victim = pointer.
REQ-024 MODE 1: on Upd with HitWay=0, pointer[PAdrSet] SHALL increment modulo NUMWAYS; a hit SHALL leave it unchanged.
REQ-025 MODE 2: SHALL keep NUMWAYS-1 bits per set in heap order (root node 0; children of node i are 2i+1 and 2i+2).
REQ-026 MODE 2 victim walk: at each node, bit 0 selects the lower half and bit 1 the upper half.
REQ-027 MODE 2 update: on Upd, accessed way W = HitWay if nonzero, else the current VictimWay; every node on W's path SHALL be set to point away from W (1 if W is in the lower half, 0 otherwise).
REQ-028 SHALL use the lowest set bit of HitWay when more than one bit is set.
REQ-029 State storage SHALL use a single write port per cycle, shared by updates and the sweep.
REQ-030 Sweep start: InvalidateCache=1 with Busy=0 SHALL set Busy=1 and counter=0 at the next edge.
REQ-031 Sweep run: each Busy cycle SHALL clear the entry at counter and then increment it; Busy SHALL fall after the entry at NUMSETS-1 is cleared, giving exactly NUMSETS Busy cycles.
REQ-032 InvalidateCache asserted while Busy=1 SHALL restart the counter at 0.
REQ-033 All requests SHALL be ignored while Busy=1.

Reset
REQ-034 reset SHALL immediately set Busy=0, sweep counter=0, LFSR=8'h01, and all per-set state (pointers and tree bits) to 0.
REQ-035 VictimWay after reset SHALL follow REQ-018 to REQ-020 from the cleared state; with all ways valid: MODE 0 gives 0010, MODE 1 and MODE 2 give 0001 (NUMWAYS=4).
REQ-036 reset asserted mid-sweep SHALL abort the sweep with all state cleared; no further Busy cycles follow.

Verification (NUMWAYS=4, NUMSETS=8)
REQ-037 Invalid-way priority: ValidWay=0101, any MODE -> VictimWay=0010; ValidWay=1111 -> policy output.
REQ-038 MODE 0, all valid, three Upd after reset -> VictimWay sequence 0010, 0100, 0001 (LFSR 01, 02, 04).
REQ-039 MODE 2, set 3: HitWay=0001 Upd -> victim 0100; then HitWay=0100 Upd -> victim 0010; other sets still 0001.
REQ-040 MODE 1, set 5: four miss Upd -> victims 0010, 0100, 1000, 0001 (wrap); a hit Upd with HitWay=0010 leaves the victim unchanged.
REQ-041 FlushStage=1 or CacheEn=0 with LRUWriteEn=1 -> no state or LFSR change.
REQ-042 Sweep: InvalidateCache pulse -> Busy high exactly 8 cycles, Upd during the sweep ignored, all sets return 0001 afterwards; reset asserted in sweep cycle 3 -> Busy=0 immediately.
